// File: rtl/mixcolumn_iter_if.sv
// Handshake bundle between the ShiftRows stage, the MixColumns engine and AddRoundKey.
// NB must match the NB of the engine it is connected to.
interface mixcolumn_iter_if #(
    parameter int NB = 4
);
    localparam int W = 32 * NB;

    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] data_i;
    logic         inv_i;
    logic         bypass_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] data_o;
    logic         busy_o;

    modport slave (
        input  in_valid_i, data_i, inv_i, bypass_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, busy_o
    );

    modport master (
        output in_valid_i, data_i, inv_i, bypass_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, busy_o
    );
endinterface

// File: rtl/mixcolumn_iter.sv
// Iterative MixColumns / InvMixColumns engine: transforms COLS_PER_CYCLE columns of an
// NB-column Rijndael state per clock, in place, with a bypass mode for the final round.
module mixcolumn_iter #(
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mixcolumn_iter_if.slave bus
);
    localparam int W  = 32 * NB;
    localparam int N  = NB / COLS_PER_CYCLE;
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    if (!(NB == 4 || NB == 6 || NB == 8) || (COLS_PER_CYCLE < 1) ||
        ((NB % COLS_PER_CYCLE) != 0)) begin : g_param_check
        $error("mixcolumn_iter: NB must be 4/6/8 and COLS_PER_CYCLE must divide NB");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [GW-1:0]  g_q, g_d;
    logic [W-1:0]   work_q, work_d;
    logic           inv_q, inv_d;
    logic           byp_q, byp_d;
    logic           in_ready_s;
    logic           accept_s;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9/B/D/E are assembled from the 2x/4x/8x chain of xt.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  s  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] res;
        logic [1:0]  r1, r2, r3;
        res = 32'h0;
        for (int i = 0; i < 4; i++) begin
            s[i]  = col[8*i +: 8];
            x2[i] = xt(s[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
        end
        for (int r = 0; r < 4; r++) begin
            r1 = 2'(r + 1);
            r2 = 2'(r + 2);
            r3 = 2'(r + 3);
            if (inv) begin
                res[8*r +: 8] = (x8[r] ^ x4[r] ^ x2[r]) ^ (x8[r1] ^ x2[r1] ^ s[r1]) ^
                                (x8[r2] ^ x4[r2] ^ s[r2]) ^ (x8[r3] ^ s[r3]);
            end else begin
                res[8*r +: 8] = x2[r] ^ (x2[r1] ^ s[r1]) ^ s[r2] ^ s[r3];
            end
        end
        return res;
    endfunction

    // Ready is a decode of the state; held low during reset so nothing is taken mid-reset.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst_i) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready_i);
        end
        accept_s = bus.in_valid_i && in_ready_s;
    end

    // Next-state, group counter and in-place working-register update.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        work_d  = work_q;
        inv_d   = inv_q;
        byp_d   = byp_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_BUSY;
                    g_d     = '0;
                    work_d  = bus.data_i;
                    inv_d   = bus.inv_i;
                    byp_d   = bus.bypass_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    work_d[32*(int'(g_q)*COLS_PER_CYCLE + k) +: 32] =
                        byp_q ? work_q[32*(int'(g_q)*COLS_PER_CYCLE + k) +: 32]
                              : mix_col(work_q[32*(int'(g_q)*COLS_PER_CYCLE + k) +: 32], inv_q);
                end
                if (g_q == GW'(N - 1)) begin
                    state_d = ST_DONE;
                    g_d     = '0;
                end else begin
                    g_d     = g_q + GW'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready_i && accept_s) begin
                    state_d = ST_BUSY;
                    g_d     = '0;
                    work_d  = bus.data_i;
                    inv_d   = bus.inv_i;
                    byp_d   = bus.bypass_i;
                end else if (bus.out_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                g_d     = '0;
            end
        endcase
    end

    // State, counter, mode and working registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            work_q  <= '0;
            inv_q   <= 1'b0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            work_q  <= work_d;
            inv_q   <= inv_d;
            byp_q   <= byp_d;
        end
    end

    assign bus.in_ready_o  = in_ready_s;
    assign bus.out_valid_o = (state_q == ST_DONE);
    assign bus.busy_o      = (state_q == ST_BUSY);
    assign bus.data_o      = work_q;
endmodule
